muxn_rr: RTL and testbench
==========================

# muxn_rr

Parametrised N-channel registered multiplexer with valid/ready handshaking. It is the successor of the 2:1 combinational data mux. It selects one of `N` input channels, either by explicit select or by round-robin arbitration, and registers the chosen word into a one-entry output stage with back-pressure. It sits between multiple producer blocks and a single shared consumer datapath.

## Interface
- `Size`, 8, data width in bits per channel (≥1)
- `N`, 4, number of input channels (≥2); `SW = $clog2(N)` is a derived localparam
- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `mode` input 1: 0 = fixed select by `sel`, 1 = round-robin
- `sel` input SW: channel index used when `mode`=0
- `in_valid` input N: per-channel valid
- `in_data` input N*Size: channel i occupies bits `[i*Size +: Size]`
- `in_ready` output N: per-channel ready, at most one bit high
- `out_valid` output 1: output register holds a word
- `out_data` output Size: registered word
- `out_ch` output SW: index of the channel that produced `out_data`
- `out_ready` input 1: consumer accepts the word

## Operation
- `accept = !out_valid || out_ready`. The output stage can load this cycle when this is true.
- Grant `g` (combinational, plus a `gnt_any` flag):
  - `mode`=0: `g = sel` and `gnt_any = in_valid[sel]`. If `sel ≥ N` (N not a power of 2), `gnt_any = 0`.
  - `mode`=1: `g` is the first i with `in_valid[i]=1`, scanning ptr+1, ptr+2, … modulo N.
- `in_ready[i] = accept && gnt_any && (g == i)`. The signal is one-hot or zero and never depends on `in_valid` of other channels through a loop.
- Input transfer on channel i happens when `in_valid[i] && in_ready[i]`. At that clock edge, `out_data <= in_data[g]`, `out_ch <= g` and `out_valid <= 1`.
- Output transfer happens when `out_valid && out_ready`. If no input transfer occurs in the same cycle, `out_valid <= 0`. If one does occur, the register is reloaded and `out_valid` stays 1.
- Round-robin pointer `ptr` (SW bits):
  - It updates to `g` only on an input transfer while `mode`=1.
  - It holds in `mode`=0.
  - Wrap-around: after the scan reaches N-1, it continues at 0.
- Stall: while `out_valid && !out_ready`, `out_data` and `out_ch` are held stable and all `in_ready` bits are 0.
- `mode` or `sel` changes take effect at the next arbitration. A word already held is not affected.
- No input valid: `gnt_any=0` and all `in_ready` bits are 0. The output stage drains normally.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - `out_valid`=0, `out_data`=0, `out_ch`=0, `ptr`=N-1 (so channel 0 wins first).
  - `in_ready`=0 while in reset.
- Reset asserted mid-transfer: the held word is discarded, with no partial state.
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 word/cycle when `out_ready` is held high.
- Fairness: in `mode`=1 with all channels continuously valid, each channel is granted exactly once every N transfers.

## Test plan
- **Reset:** N=4, Size=8. Hold `rst_n`=0 with all `in_valid`=1.
  - Require `out_valid`=0, `out_data`=0x00 and `in_ready`=0000.
  - Release reset with `mode`=1. The first transfer must be from channel 0.
- **Fixed select:** `mode`=0, `sel`=2, `in_data` ch2=0xA5, `in_valid`=1111, `out_ready`=1.
  - Require `in_ready`=0100.
  - Next cycle `out_valid`=1, `out_data`=0xA5, `out_ch`=2.
  - Set `in_valid[2]`=0: `in_ready`=0000 and `out_valid` drops after one cycle.
- **Round-robin fairness and wrap:** `mode`=1, all valid, ch i data = 0x10+i, `out_ready`=1 for 8 cycles.
  - Require `out_ch` sequence 0,1,2,3,0,1,2,3 with matching data.
  - Then `in_valid`=1001: sequence 0,3,0,3.
- **Back-pressure:** `out_ready`=0 for 3 cycles while `out_valid`=1 with `out_data`=0x11.
  - `out_data`/`out_ch` must stay constant and `in_ready`=0000.
  - Raise `out_ready`: a simultaneous drain and load occurs, and the next word appears the following cycle with no bubble.
- **Mode switch and pointer hold:** in `mode`=1, last grant ch1. Switch to `mode`=0, `sel`=3 for 2 transfers, then back to `mode`=1 with all valid.
  - The next grant must be ch2, confirming the pointer was held.
- **Reset mid-stall:** `out_valid`=1, `out_ready`=0, then pulse `rst_n` low asynchronously between edges.
  - `out_valid` must go 0 immediately. After release, the first grant is ch0.

Source files
------------

// File: rtl/muxn_rr_if.sv
// Handshake bundle between N producers, the muxn_rr arbiter and one shared consumer.
// The master side is the producers plus the consumer; the slave side is the mux itself.
interface muxn_rr_if #(
  parameter int Size = 8,
  parameter int N    = 4
);
  localparam int SW = $clog2(N);

  logic                mode;
  logic [SW-1:0]       sel;
  logic [N-1:0]        in_valid;
  logic [N*Size-1:0]   in_data;
  logic [N-1:0]        in_ready;
  logic                out_valid;
  logic [Size-1:0]     out_data;
  logic [SW-1:0]       out_ch;
  logic                out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/muxn_rr.sv
// N-channel registered multiplexer with a one-entry output stage and back-pressure.
// Channels are chosen either by an explicit select or by round-robin arbitration.
module muxn_rr #(
  parameter int Size = 8,
  parameter int N    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  muxn_rr_if.slave    bus
);
  localparam int SW = $clog2(N);

  logic            valid_q;
  logic [Size-1:0] data_q;
  logic [SW-1:0]   ch_q;
  logic [SW-1:0]   ptr;

  logic            accept;
  logic            load;
  logic            gnt_any;
  logic [SW-1:0]   g;
  logic [SW-1:0]   cand;
  logic [Size-1:0] sel_data;

  assign accept = !valid_q || bus.out_ready;
  assign load   = accept && gnt_any;

  // Round-robin scans from the farthest candidate back to ptr+1, so the nearest valid one wins.
  always_comb begin
    g       = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (!bus.mode) begin
      g = bus.sel;
      for (int i = 0; i < N; i++) begin
        if (bus.sel == SW'(i)) begin
          gnt_any = bus.in_valid[i];
        end
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        cand = SW'((int'(ptr) + k) % N);
        if (bus.in_valid[cand]) begin
          g       = cand;
          gnt_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data    = '0;
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SW'(i)) begin
        sel_data        = bus.in_data[i*Size +: Size];
        bus.in_ready[i] = rst_n && load;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr     <= SW'(N - 1);
    end else begin
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= sel_data;
        ch_q    <= g;
        if (bus.mode) begin
          ptr <= g;
        end
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_muxn_rr.sv
// Scenario bench for muxn_rr: expected words are queued as stimulus is applied
// and popped as the output stage hands them to the consumer.
module tb_muxn_rr;
  localparam int Size = 8;
  localparam int N    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_w;

  muxn_rr_if #(.Size(Size), .N(N)) bus();

  muxn_rr #(.Size(Size), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.mode = 1'b1;
    bus.sel = '0;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b0;
    bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    repeat (2) @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b, required 0", bus.out_valid); end
    n_assert++;
    if ({bus.out_ch, bus.out_data} !== 10'h000) begin n_fail++; $display("[TB] FAIL reset_data: got ch=%0d data=%h, required ch=0 data=00", bus.out_ch, bus.out_data); end
    n_assert++;
    if (bus.in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_ready: got %b, required 0000", bus.in_ready); end
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.push_back({2'd0, 8'h10});
    #1;
    n_assert++;
    if (bus.in_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL reset_first_grant: got %b, required 0001", bus.in_ready); end
    @(negedge clk);
    exp_w = exp_q.pop_front();
    n_assert++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_w}) begin n_fail++; $display("[TB] FAIL reset_first_word: got v=%b ch=%0d data=%h, required v=1 ch=%0d data=%h", bus.out_valid, bus.out_ch, bus.out_data, exp_w[9:8], exp_w[7:0]); end
    bus.in_valid = 4'b0000;
    @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_drain: got %b, required 0", bus.out_valid); end
  endtask

  task automatic test_fixed_select();
    bus.mode = 1'b0;
    bus.sel = 2'd2;
    bus.in_data = {8'h33, 8'hA5, 8'h11, 8'h10};
    bus.in_valid = 4'b1111;
    exp_q.push_back({2'd2, 8'hA5});
    #1;
    n_assert++;
    if (bus.in_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL fixed_ready: got %b, required 0100", bus.in_ready); end
    @(negedge clk);
    exp_w = exp_q.pop_front();
    n_assert++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_w}) begin n_fail++; $display("[TB] FAIL fixed_word: got v=%b ch=%0d data=%h, required v=1 ch=%0d data=%h", bus.out_valid, bus.out_ch, bus.out_data, exp_w[9:8], exp_w[7:0]); end
    bus.in_valid = 4'b1011;
    #1;
    n_assert++;
    if (bus.in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL fixed_idle_ready: got %b, required 0000", bus.in_ready); end
    @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fixed_drop: got %b, required 0", bus.out_valid); end
  endtask

  task automatic test_round_robin();
    bus.mode = 1'b1;
    bus.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.in_valid = 4'b1000;
    exp_q.push_back({2'd3, 8'h13});
    @(negedge clk);
    exp_w = exp_q.pop_front();
    n_assert++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_w}) begin n_fail++; $display("[TB] FAIL rr_prelude: got v=%b ch=%0d data=%h, required v=1 ch=%0d data=%h", bus.out_valid, bus.out_ch, bus.out_data, exp_w[9:8], exp_w[7:0]); end
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 8; i++) exp_q.push_back({2'(i % 4), 8'(8'h10 + i % 4)});
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      n_assert++;
      if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_w}) begin n_fail++; $display("[TB] FAIL rr_seq[%0d]: got v=%b ch=%0d data=%h, required v=1 ch=%0d data=%h", c, bus.out_valid, bus.out_ch, bus.out_data, exp_w[9:8], exp_w[7:0]); end
      if (c == 7) begin
        bus.in_valid = 4'b1001;
        exp_q.push_back({2'd0, 8'h10});
        exp_q.push_back({2'd3, 8'h13});
        exp_q.push_back({2'd0, 8'h10});
        exp_q.push_back({2'd3, 8'h13});
      end
      if (c == 11) bus.in_valid = 4'b0000;
    end
    @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rr_drain: got %b, required 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.in_data = {8'h33, 8'h12, 8'h11, 8'h10};
    bus.in_valid = 4'b0010;
    bus.out_ready = 1'b0;
    exp_q.push_back({2'd1, 8'h11});
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      if (s == 0) bus.in_valid = 4'b0100;
      #1;
      n_assert++;
      if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, 2'd1, 8'h11}) begin n_fail++; $display("[TB] FAIL stall_hold[%0d]: got v=%b ch=%0d data=%h, required v=1 ch=1 data=11", s, bus.out_valid, bus.out_ch, bus.out_data); end
      n_assert++;
      if (bus.in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL stall_ready[%0d]: got %b, required 0000", s, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    exp_q.push_back({2'd2, 8'h12});
    #1;
    n_assert++;
    if (bus.in_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL stall_release_ready: got %b, required 0100", bus.in_ready); end
    exp_w = exp_q.pop_front();
    n_assert++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_w}) begin n_fail++; $display("[TB] FAIL stall_drain_word: got v=%b ch=%0d data=%h, required v=1 ch=%0d data=%h", bus.out_valid, bus.out_ch, bus.out_data, exp_w[9:8], exp_w[7:0]); end
    @(negedge clk);
    exp_w = exp_q.pop_front();
    n_assert++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_w}) begin n_fail++; $display("[TB] FAIL stall_next_word: got v=%b ch=%0d data=%h, required v=1 ch=%0d data=%h", bus.out_valid, bus.out_ch, bus.out_data, exp_w[9:8], exp_w[7:0]); end
    bus.in_valid = 4'b0000;
    @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_drain: got %b, required 0", bus.out_valid); end
  endtask

  task automatic test_mode_switch();
    bus.in_data = {8'h33, 8'h22, 8'h11, 8'h10};
    bus.mode = 1'b1;
    bus.in_valid = 4'b0010;
    bus.out_ready = 1'b1;
    exp_q.push_back({2'd1, 8'h11});
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      exp_w = exp_q.pop_front();
      n_assert++;
      if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_w}) begin n_fail++; $display("[TB] FAIL mode_seq[%0d]: got v=%b ch=%0d data=%h, required v=1 ch=%0d data=%h", c, bus.out_valid, bus.out_ch, bus.out_data, exp_w[9:8], exp_w[7:0]); end
      if (c == 0) begin
        bus.mode = 1'b0;
        bus.sel = 2'd3;
        bus.in_valid = 4'b1111;
        exp_q.push_back({2'd3, 8'h33});
        exp_q.push_back({2'd3, 8'h33});
      end else if (c == 2) begin
        bus.mode = 1'b1;
        exp_q.push_back({2'd2, 8'h22});
        #1;
        n_assert++;
        if (bus.in_ready !== 4'b0100) begin n_fail++; $display("[TB] FAIL mode_ptr_hold: got %b, required 0100", bus.in_ready); end
      end else if (c == 3) begin
        bus.in_valid = 4'b0000;
      end
    end
    @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mode_drain: got %b, required 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    bus.in_data = {8'h33, 8'h22, 8'h11, 8'h10};
    bus.mode = 1'b1;
    bus.in_valid = 4'b1000;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, 2'd3, 8'h33}) begin n_fail++; $display("[TB] FAIL midrst_held: got v=%b ch=%0d data=%h, required v=1 ch=3 data=33", bus.out_valid, bus.out_ch, bus.out_data); end
    bus.in_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== 11'h000) begin n_fail++; $display("[TB] FAIL midrst_clear: got v=%b ch=%0d data=%h, required v=0 ch=0 data=00", bus.out_valid, bus.out_ch, bus.out_data); end
    n_assert++;
    if (bus.in_ready !== 4'b0000) begin n_fail++; $display("[TB] FAIL midrst_ready: got %b, required 0000", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 4'b1111;
    bus.out_ready = 1'b1;
    exp_q.push_back({2'd0, 8'h10});
    #1;
    n_assert++;
    if (bus.in_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL midrst_first_grant: got %b, required 0001", bus.in_ready); end
    @(negedge clk);
    exp_w = exp_q.pop_front();
    n_assert++;
    if ({bus.out_valid, bus.out_ch, bus.out_data} !== {1'b1, exp_w}) begin n_fail++; $display("[TB] FAIL midrst_first_word: got v=%b ch=%0d data=%h, required v=1 ch=%0d data=%h", bus.out_valid, bus.out_ch, bus.out_data, exp_w[9:8], exp_w[7:0]); end
    bus.in_valid = 4'b0000;
    @(negedge clk);
    n_assert++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_drain: got %b, required 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_fixed_select();
    test_round_robin();
    test_back_to_back();
    test_mode_switch();
    test_reset_mid_stall();
    n_assert++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL scoreboard_empty: got %0d words left, required 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
